// File: rtl/ball_draw_if.sv
// ---------------------------------------------------------------------------
// ball_draw_if
// Bundles the request side (from the game FSM) and the pixel stream side
// (towards the x/y-to-address RAM writer) of the ball_draw block.
//
// Signals:
//   start     request: draw the square at (x0, y0), single-cycle pulse
//   clr       request: flood the screen with color_in, single-cycle pulse
//   x0        square origin column (8 bits)
//   y0        square origin row (9 bits)
//   color_in  RGB colour, bit 2 = R, bit 1 = G, bit 0 = B
//   busy      high while a draw or clear is in progress
//   done      one-cycle pulse when an operation finishes
//   x, y      pixel coordinate
//   write_en  pixel valid strobe
//   color     pixel colour
//
// Modports:
//   master  the requester side (game FSM / testbench)
//   slave   the ball_draw block itself
// ---------------------------------------------------------------------------
interface ball_draw_if;
  logic       start;
  logic       clr;
  logic [7:0] x0;
  logic [8:0] y0;
  logic [2:0] color_in;
  logic       busy;
  logic       done;
  logic [7:0] x;
  logic [8:0] y;
  logic       write_en;
  logic [2:0] color;

  modport master (
    output start, clr, x0, y0, color_in,
    input  busy, done, x, y, write_en, color
  );

  modport slave (
    input  start, clr, x0, y0, color_in,
    output busy, done, x, y, write_en, color
  );
endinterface

// File: rtl/ball_draw.sv
// ---------------------------------------------------------------------------
// ball_draw
// Pixel-stream generator feeding the x/y-to-address RAM writer. On a start
// request it rasterises a filled BALL_SIZE x BALL_SIZE square whose top-left
// corner is (x0, y0); on a clr request it floods the whole SCR_W x SCR_H
// screen with one colour. One pixel is produced per clock in raster order
// (x fastest). Pixels of the square that fall off the screen are clipped by
// holding write_en low while the counters keep running, so the operation
// length never depends on the origin.
//
// Ports:
//   clk50M  system clock
//   rst_n   asynchronous active-low reset
//   bus     ball_draw_if.slave: start/clr/x0/y0/color_in requests in,
//           busy/done status and x/y/write_en/color pixel stream out
//
// All outputs are registered. The first pixel appears in the cycle right
// after the request is sampled.
// ---------------------------------------------------------------------------
module ball_draw #(
  parameter int BALL_SIZE = 8,
  parameter int SCR_W     = 240,
  parameter int SCR_H     = 320
) (
  input  logic        clk50M,
  input  logic        rst_n,
  ball_draw_if.slave  bus
);

  // Last counter values for each operation. The column counter is 8 bits
  // (enough for 0..SCR_W-1), the row counter 9 bits (0..SCR_H-1); the square
  // reuses the same two counters as its dx/dy offsets.
  localparam logic [7:0] DRAW_COL_LAST = 8'(BALL_SIZE - 1);
  localparam logic [8:0] DRAW_ROW_LAST = 9'(BALL_SIZE - 1);
  localparam logic [7:0] CLR_COL_LAST  = 8'(SCR_W - 1);
  localparam logic [8:0] CLR_ROW_LAST  = 9'(SCR_H - 1);
  localparam logic [8:0] SCR_W_LIM     = 9'(SCR_W);
  localparam logic [9:0] SCR_H_LIM     = 10'(SCR_H);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    CLEAR = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] colCnt_q, colCnt_d;
  logic [8:0] rowCnt_q, rowCnt_d;
  logic [7:0] orgX_q, orgX_d;
  logic [8:0] orgY_q, orgY_d;
  logic [2:0] colLatch_q, colLatch_d;

  logic [7:0] x_q, x_d;
  logic [8:0] y_q, y_d;
  logic [2:0] color_q, color_d;
  logic       we_q, we_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;

  // Pixel coordinate of the square, one bit wider than the screen
  // coordinates so that positions past the right/bottom edge are seen as
  // such instead of wrapping around.
  logic [8:0] colSum;
  logic [9:0] rowSum;
  logic       onScreen;

  // State register plus every registered output. Reset clears everything,
  // so an interrupted operation never produces a done pulse.
  always_ff @(posedge clk50M or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      colCnt_q   <= '0;
      rowCnt_q   <= '0;
      orgX_q     <= '0;
      orgY_q     <= '0;
      colLatch_q <= '0;
      x_q        <= '0;
      y_q        <= '0;
      color_q    <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      colCnt_q   <= colCnt_d;
      rowCnt_q   <= rowCnt_d;
      orgX_q     <= orgX_d;
      orgY_q     <= orgY_d;
      colLatch_q <= colLatch_d;
      x_q        <= x_d;
      y_q        <= y_d;
      color_q    <= color_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // Next-state logic. The counters always describe the pixel currently on
  // the outputs, so the move to DONE happens while the last pixel is shown.
  // Requests are only looked at in IDLE; clr has priority over start.
  always_comb begin
    state_d    = state_q;
    colCnt_d   = colCnt_q;
    rowCnt_d   = rowCnt_q;
    orgX_d     = orgX_q;
    orgY_d     = orgY_q;
    colLatch_d = colLatch_q;
    case (state_q)
      IDLE: begin
        if (bus.clr || bus.start) begin
          state_d    = bus.clr ? CLEAR : DRAW;
          colCnt_d   = '0;
          rowCnt_d   = '0;
          orgX_d     = bus.x0;
          orgY_d     = bus.y0;
          colLatch_d = bus.color_in;
        end
      end
      DRAW: begin
        if (colCnt_q == DRAW_COL_LAST) begin
          colCnt_d = '0;
          if (rowCnt_q == DRAW_ROW_LAST) begin
            rowCnt_d = '0;
            state_d  = DONE;
          end else begin
            rowCnt_d = rowCnt_q + 9'd1;
          end
        end else begin
          colCnt_d = colCnt_q + 8'd1;
        end
      end
      CLEAR: begin
        if (colCnt_q == CLR_COL_LAST) begin
          colCnt_d = '0;
          if (rowCnt_q == CLR_ROW_LAST) begin
            rowCnt_d = '0;
            state_d  = DONE;
          end else begin
            rowCnt_d = rowCnt_q + 9'd1;
          end
        end else begin
          colCnt_d = colCnt_q + 8'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output logic. It looks at the *next* state and counters so that the
  // registered outputs line up with the state they belong to; this is what
  // puts the first pixel on the bus the cycle after the request.
  always_comb begin
    colSum   = {1'b0, orgX_d} + {1'b0, colCnt_d};
    rowSum   = {1'b0, orgY_d} + {1'b0, rowCnt_d};
    onScreen = (colSum < SCR_W_LIM) && (rowSum < SCR_H_LIM);
    x_d      = x_q;
    y_d      = y_q;
    color_d  = color_q;
    we_d     = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      DRAW: begin
        busy_d  = 1'b1;
        x_d     = colSum[7:0];
        y_d     = rowSum[8:0];
        color_d = colLatch_d;
        we_d    = onScreen;
      end
      CLEAR: begin
        busy_d  = 1'b1;
        x_d     = colCnt_d;
        y_d     = rowCnt_d;
        color_d = colLatch_d;
        we_d    = 1'b1;
      end
      DONE: begin
        done_d = 1'b1;
      end
      default: begin
        we_d = 1'b0;
      end
    endcase
  end

  assign bus.x        = x_q;
  assign bus.y        = y_q;
  assign bus.color    = color_q;
  assign bus.write_en = we_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;

endmodule
